// File: rtl/proc_pkg.sv
// Shared definitions for the processor front-panel blocks.
// Holds the step-control FSM state type and the board-level default
// constants (50 MHz clock, 1 ms debounce, 4 Hz auto-run rate).
package proc_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000;
  localparam int unsigned RUN_PERIOD_DEF      = CLK_HZ / 4;
  localparam int unsigned CNT_W_DEF           = 16;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } step_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser, debouncer and press-event generator for one raw
// active-low push key.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   key_n     - raw key, 0 = pressed, asynchronous to clk
//   pressed   - debounced key level, 1 = held
//   press_evt - one-cycle pulse, one cycle after pressed rises
module key_debounce
  import proc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_evt
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 32'd1);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pressed_q, pressed_d;
  logic            pressed_dly_q;
  logic            evt_q, evt_d;
  logic            key_lvl;

  // Synchroniser, debounce state and event register; sync flops idle released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      db_cnt_q      <= {DB_W{1'b0}};
      pressed_q     <= 1'b0;
      pressed_dly_q <= 1'b0;
      evt_q         <= 1'b0;
    end else begin
      sync1_q       <= key_n;
      sync2_q       <= sync1_q;
      db_cnt_q      <= db_cnt_d;
      pressed_q     <= pressed_d;
      pressed_dly_q <= pressed_q;
      evt_q         <= evt_d;
    end
  end

  // Count consecutive cycles the synced level disagrees with the accepted
  // level; accept the change only after an unbroken run.
  always_comb begin
    key_lvl   = ~sync2_q;
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    if (key_lvl != pressed_q) begin
      if (db_cnt_q == DB_LAST) begin
        pressed_d = ~pressed_q;
        db_cnt_d  = {DB_W{1'b0}};
      end else begin
        db_cnt_d  = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
    // Rising edge of the accepted level only; release gives no event.
    evt_d = pressed_q & ~pressed_dly_q;
  end

  assign pressed   = pressed_q;
  assign press_evt = evt_q;

endmodule

// File: rtl/step_ctrl.sv
// Step-control stage feeding the processor's single-cycle step enable.
// Manual mode: one Step per debounced key press. Run mode: Step every
// RUN_PERIOD cycles, the key toggles pause. Counts issued steps.
// Ports:
//   Clk       - system clock
//   Reset     - asynchronous active-low reset
//   KeyIn     - raw active-low step key
//   RunMode   - 0 manual, 1 auto run (switch, synchronised here)
//   Halt      - synchronous, masks all Step pulses
//   Step      - registered one-cycle step pulse
//   Pressed   - debounced key level
//   Paused    - 1 while auto run is paused
//   StepCount - Step pulses since reset, wraps
module step_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RUN_PERIOD      = RUN_PERIOD_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             KeyIn,
  input  logic             RunMode,
  input  logic             Halt,
  output logic             Step,
  output logic             Pressed,
  output logic             Paused,
  output logic [CNT_W-1:0] StepCount
);

  localparam int unsigned PER_W = cnt_width(RUN_PERIOD);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(RUN_PERIOD - 32'd1);

  logic             press_evt;
  logic             run_s1_q, run_s2_q;
  step_state_t      state_q, state_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             step_q, step_d;
  logic             paused_q, paused_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_req;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk      (Clk),
    .rst_n    (Reset),
    .key_n    (KeyIn),
    .pressed  (Pressed),
    .press_evt(press_evt)
  );

  // RunMode synchroniser, FSM state, period counter and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
      state_q   <= MANUAL;
      per_cnt_q <= {PER_W{1'b0}};
      step_q    <= 1'b0;
      paused_q  <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
    end else begin
      run_s1_q  <= RunMode;
      run_s2_q  <= run_s1_q;
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      step_q    <= step_d;
      paused_q  <= paused_d;
      count_q   <= count_d;
    end
  end

  // Next-state and step request. A mode change outranks a press, and a
  // press in RUN outranks a period wrap; the outranked event is dropped.
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    step_req  = 1'b0;
    case (state_q)
      MANUAL: begin
        if (run_s2_q) begin
          state_d   = RUN;
          per_cnt_d = {PER_W{1'b0}};
        end else begin
          step_req = press_evt;
        end
      end
      RUN: begin
        if (!run_s2_q) begin
          state_d = MANUAL;
        end else if (press_evt) begin
          state_d = PAUSED;
        end else if (per_cnt_q == PER_LAST) begin
          per_cnt_d = {PER_W{1'b0}};
          step_req  = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q + PER_W'(1);
        end
      end
      PAUSED: begin
        if (!run_s2_q) begin
          state_d = MANUAL;
        end else if (press_evt) begin
          state_d   = RUN;
          per_cnt_d = {PER_W{1'b0}};
        end else begin
          state_d = PAUSED;
        end
      end
      default: begin
        state_d   = MANUAL;
        per_cnt_d = {PER_W{1'b0}};
      end
    endcase
    // Halt drops the request outright: masked steps are never replayed.
    step_d   = step_req & ~Halt;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, step_d};
    paused_d = (state_d == PAUSED);
  end

  assign Step      = step_q;
  assign Paused    = paused_q;
  assign StepCount = count_q;

endmodule

// File: tb/tb_step_ctrl.sv
module tb_step_ctrl;

  localparam int DEB = 4;
  localparam int RP  = 8;

  logic        clk, rst_n, key_in, run_mode, halt;
  logic        step, pressed, paused;
  logic [15:0] step_count;

  int n_assert = 0;
  int n_fail   = 0;
  logic prev_step;

  // Reference model state (values as they stand after the last clock edge)
  logic        m_k1, m_k2, m_r1, m_r2;
  int          m_run;
  logic        m_pressed, m_pressed_prev, m_evt;
  int          m_mode;   // 0 manual, 1 run, 2 paused
  int          m_phase;  // cycles elapsed in current run period
  logic        m_step, m_paused;
  logic [15:0] m_count;

  typedef struct {
    logic key;
    logic run;
    logic hlt;
    int   cycles;
    int   exp_steps;
    int   exp_first;
    int   exp_count;
    logic exp_pressed;
    logic exp_paused;
  } vec_t;

  vec_t tbl[$];

  step_ctrl #(.DEBOUNCE_CYCLES(DEB), .RUN_PERIOD(RP), .CNT_W(16)) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .KeyIn    (key_in),
    .RunMode  (run_mode),
    .Halt     (halt),
    .Step     (step),
    .Pressed  (pressed),
    .Paused   (paused),
    .StepCount(step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k1 = 1'b1; m_k2 = 1'b1; m_r1 = 1'b0; m_r2 = 1'b0;
    m_run = 0; m_pressed = 1'b0; m_pressed_prev = 1'b0; m_evt = 1'b0;
    m_mode = 0; m_phase = 0; m_step = 1'b0; m_paused = 1'b0; m_count = 16'h0000;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_tick();
    logic want, n_evt, n_pressed;
    int   n_mode, n_phase;
    if (!rst_n) begin
      model_reset();
    end else begin
      want = 1'b0; n_mode = m_mode; n_phase = m_phase;
      if (m_mode == 0) begin
        if (m_r2) begin n_mode = 1; n_phase = 0; end
        else want = m_evt;
      end else if (m_mode == 1) begin
        if (!m_r2) n_mode = 0;
        else if (m_evt) n_mode = 2;
        else begin
          want    = (m_phase == RP - 1);
          n_phase = (m_phase + 1) % RP;
        end
      end else begin
        if (!m_r2) n_mode = 0;
        else if (m_evt) begin n_mode = 1; n_phase = 0; end
      end
      n_evt = m_pressed && !m_pressed_prev;
      n_pressed = m_pressed;
      if ((!m_k2) != m_pressed) begin
        m_run++;
        if (m_run == DEB) begin n_pressed = !m_pressed; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_step = want && !halt;
      if (m_step) m_count = m_count + 16'd1;
      m_paused = (n_mode == 2);
      m_mode = n_mode; m_phase = n_phase;
      m_pressed_prev = m_pressed; m_pressed = n_pressed; m_evt = n_evt;
      m_k2 = m_k1; m_k1 = key_in; m_r2 = m_r1; m_r1 = run_mode;
    end
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
    check("model.step", step, m_step);
    check("model.pressed", pressed, m_pressed);
    check("model.paused", paused, m_paused);
    check("model.count", step_count, m_count);
    check("step_gap", step & prev_step, 1'b0);
    prev_step = step;
  endtask

  task automatic run_seg(input vec_t v, input string tag);
    int steps, first;
    key_in = v.key; run_mode = v.run; halt = v.hlt;
    steps = 0; first = 0;
    for (int c = 1; c <= v.cycles; c++) begin
      cycle();
      if (step) begin
        steps++;
        if (first == 0) first = c;
      end
    end
    check({tag, ".steps"}, steps, v.exp_steps);
    check({tag, ".first"}, first, v.exp_first);
    check({tag, ".count"}, step_count, v.exp_count);
    check({tag, ".pressed"}, pressed, v.exp_pressed);
    check({tag, ".paused"}, paused, v.exp_paused);
  endtask

  initial begin
    int hold;
    vec_t v;
    clk = 1'b0; rst_n = 1'b0; key_in = 1'b1; run_mode = 1'b0; halt = 1'b0;
    prev_step = 1'b0;
    model_reset();
    repeat (3) cycle();
    check("rst.step", step, 1'b0);
    check("rst.pressed", pressed, 1'b0);
    check("rst.paused", paused, 1'b0);
    check("rst.count", step_count, 16'h0000);
    rst_n = 1'b1;

    // key, run, halt, cycles, steps, first step cycle, count, pressed, paused
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 0,  0,  0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 20, 1,  8,  1, 1'b1, 1'b0}); // clean press
    tbl.push_back('{1'b1, 1'b0, 1'b0, 20, 0,  0,  1, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++)                                    // bounce
      tbl.push_back('{(i % 2 == 1), 1'b0, 1'b0, 2, 0, 0, 1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 12, 1,  8,  2, 1'b1, 1'b0}); // settle
    tbl.push_back('{1'b1, 1'b0, 1'b0, 12, 0,  0,  2, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 44, 5, 11,  7, 1'b0, 1'b0}); // auto run
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 0,  0,  7, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 0,  0,  7, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 30, 0,  0,  7, 1'b1, 1'b1}); // pause
    tbl.push_back('{1'b1, 1'b1, 1'b0, 30, 0,  0,  7, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 20, 1, 16,  8, 1'b1, 1'b0}); // resume
    tbl.push_back('{1'b1, 1'b1, 1'b0,  8, 1,  4,  9, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 24, 0,  0,  9, 1'b0, 1'b0}); // halt
    tbl.push_back('{1'b1, 1'b1, 1'b0,  5, 1,  4, 10, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  6, 0,  0, 10, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) run_seg(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a debounce
    key_in = 1'b0;
    repeat (4) cycle();
    rst_n = 1'b0; key_in = 1'b1;
    model_reset();
    #1;
    check("arst.step", step, 1'b0);
    check("arst.pressed", pressed, 1'b0);
    check("arst.paused", paused, 1'b0);
    check("arst.count", step_count, 16'h0000);
    repeat (3) cycle();
    rst_n = 1'b1;
    v = '{1'b1, 1'b0, 1'b0, 20, 0, 0, 0, 1'b0, 1'b0};
    run_seg(v, "after_rst");

    // Key held through reset release
    rst_n = 1'b0; key_in = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    v = '{1'b0, 1'b0, 1'b0, 20, 1, 8, 1, 1'b1, 1'b0};
    run_seg(v, "held_rst");
    v = '{1'b1, 1'b0, 1'b0, 12, 0, 0, 1, 1'b0, 1'b0};
    run_seg(v, "held_rel");

    // Counter wrap from a preloaded 0xFFFF
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    cycle();
    release dut.count_q;
    v = '{1'b0, 1'b0, 1'b0, 20, 1, 8, 0, 1'b1, 1'b0};
    run_seg(v, "wrap");
    v = '{1'b1, 1'b0, 1'b0, 12, 0, 0, 0, 1'b0, 1'b0};
    run_seg(v, "wrap_rel");

    // Randomised traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        key_in = ~key_in;
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 79) == 0) run_mode = ~run_mode;
      halt = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Step-control stage directly upstream of the Processor; drives its single-cycle clock-enable/step input.
- Synchronises and debounces a raw active-low push key; emits exactly one Step pulse per press in manual mode.
- In run mode, emits Step at a fixed programmable rate; the key toggles pause.
- Keeps a 16-bit step counter for HEX display.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a key level change (1 ms at 50 MHz).
- RUN_PERIOD, 12500000, cycles between auto Step pulses in run mode (4 Hz at 50 MHz); must be >= 2.
- CNT_W, 16, width of StepCount.

Ports:
- Clk, input, 1, system clock (CLOCK_50).
- Reset, input, 1, asynchronous active-low reset.
- KeyIn, input, 1, raw push key, active-low (0 = pressed), asynchronous to Clk.
- RunMode, input, 1, 0 = manual single-step, 1 = auto run; from a switch, synchronised internally.
- Halt, input, 1, synchronous, 1 = suppress all Step pulses (processor halted).
- Step, output, 1, one-Clk-cycle pulse; Processor advances one state per pulse.
- Pressed, output, 1, debounced key level, 1 = held.
- Paused, output, 1, 1 when in the PAUSED state.
- StepCount, output, CNT_W, number of Step pulses issued since reset; wraps.

Behaviour:
- Reset (Reset = 0, async): Step = 0, Pressed = 0, Paused = 0, StepCount = 0. Synchroniser flops reset to 1 (key released). Debounce and period counters reset to 0. FSM goes to MANUAL.
- Synchroniser: 2-flop chain on KeyIn and RunMode; 2-cycle latency.
- Debounce:
  - When the synced key level differs from Pressed, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, Pressed flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves Pressed unchanged.
- Press event: a one-cycle internal pulse on the Pressed 0->1 transition. Release produces no event.
- FSM states: MANUAL, RUN, PAUSED.
  - MANUAL: a press event gives Step = 1 in the next cycle. RunMode = 1 -> RUN, with the period counter cleared.
  - RUN: the period counter counts 0..RUN_PERIOD-1. At RUN_PERIOD-1, Step = 1 in the next cycle and the counter wraps to 0. A press event -> PAUSED and no Step. RunMode = 0 -> MANUAL.
  - PAUSED: the counter holds. A press event -> RUN with the counter cleared and no immediate Step. RunMode = 0 -> MANUAL.
- Simultaneous events:
  - A RunMode change has priority over a press event in the same cycle; the press is consumed and no Step is issued.
  - A press in MANUAL that coincides with RunMode rising: no Step is issued.
- Halt = 1 masks Step, and StepCount does not increment. FSM and counters keep running; masked steps are lost, not queued.
- Step is registered and is never high in two consecutive cycles. StepCount increments in the same cycle Step is asserted and wraps 0xFFFF -> 0x0000.
- Latency: a key edge reaches Step after 2 sync cycles + DEBOUNCE_CYCLES + 1 event cycle + 1 output-register cycle.
- A reset mid-debounce or mid-period discards all progress. A key held through reset release produces a press event once debounced.

Decomposition:
- Shared package proc_pkg holds the FSM enum step_state_t {MANUAL, RUN, PAUSED} and the default constants (CLK_HZ = 50_000_000).
- One sub-module, key_debounce (synchroniser + debounce + press-event pulse), reusable for the other board keys. The FSM and counters stay in step_ctrl.

Test Plan (all tests use DEBOUNCE_CYCLES = 4, RUN_PERIOD = 8):
- Clean press (KeyIn low for 20 cycles, then high) in MANUAL -> exactly one Step, 8 cycles after the falling edge (2 sync + 4 debounce + 1 event + 1 output); StepCount = 1; Pressed high for 20 cycles.
- Bounce (KeyIn toggles low/high every 2 cycles for 12 cycles, then settles low) -> exactly one Step, 4 debounce cycles after the settle plus fixed latency; StepCount = 1.
- RunMode = 1 held for 40 cycles, Halt = 0 -> Step at period-counter wrap every 8 cycles; 5 pulses; StepCount = 5.
- RUN, then a press -> Paused = 1 and no Step for 30 cycles; a second press -> Paused = 0 and the first Step comes 8 cycles after re-entering RUN.
- Halt = 1 during RUN for 24 cycles -> Step stays 0 and StepCount is unchanged. After Halt drops, the next Step comes at the next counter wrap.
- Preload 0xFFFF pulses (forced), then one press -> StepCount = 0x0000. Async Reset asserted mid-debounce -> all outputs are 0 immediately, and no Step after release.
